// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter with a registered select that drives
// a combinational data multiplexer. Each grant is held until the downstream
// side accepts it or the requester withdraws.
// Optional watchdog: define ARB_TIMEOUT_EN to revoke grants that are stalled
// by out_ready for 15 counted cycles.
module rr_mux_arbiter #(
  parameter int NREQ = 8,
  parameter int DW   = 32,
  parameter int SW   = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*DW-1:0]  req_data,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [DW-1:0]       out_data,
  output logic [SW-1:0]       SEL,
  output logic [NREQ-1:0]     grant,
  output logic [NREQ-1:0]     ack,
  output logic                timeout
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]      state_reg, state_next;
  logic [SW-1:0]   ptr_reg, ptr_next;
  logic [SW-1:0]   sel_reg, sel_next;
  logic [NREQ-1:0] grant_reg, grant_next;
  logic [NREQ-1:0] sel_onehot;
  logic [SW-1:0]   pick_idx;
  logic [SW-1:0]   cand;
  logic            pick_found;
  logic            accept;
  logic [DW-1:0]   words [NREQ];

`ifdef ARB_TIMEOUT_EN
  logic [3:0]      wd_reg, wd_next;
  logic            timeout_reg, timeout_next;
`endif

  // Unpack the flat data bus into one word per requester for the select mux.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_words
    assign words[gi] = req_data[gi*DW +: DW];
  end

  assign sel_onehot = NREQ'(1) << sel_reg;
  assign out_valid  = (state_reg == GRANT);
  assign out_data   = words[sel_reg];
  assign SEL        = sel_reg;
  assign grant      = grant_reg;
  // A transfer completes when a held grant meets a ready sink; reset wins.
  assign accept     = out_valid && out_ready && !rst;
  assign ack        = accept ? sel_onehot : '0;

`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_reg;
`else
  assign timeout = 1'b0;
`endif

  // Search upward from ptr, wrapping, for the first active request.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_reg;
    cand       = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = ptr_reg + SW'(i);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state logic for the IDLE/GRANT handshake.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    sel_next   = sel_reg;
    grant_next = grant_reg;
`ifdef ARB_TIMEOUT_EN
    wd_next      = wd_reg;
    timeout_next = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next = GRANT;
          sel_next   = pick_idx;
          grant_next = NREQ'(1) << pick_idx;
`ifdef ARB_TIMEOUT_EN
          wd_next    = 4'd0;
`endif
        end
      end
      default: begin
        if (accept) begin
          // Advance fairness pointer past the requester just served.
          state_next = IDLE;
          grant_next = '0;
          ptr_next   = sel_reg + SW'(1);
        end else if (!req[sel_reg]) begin
          // Requester withdrew: cancel without moving the pointer.
          state_next = IDLE;
          grant_next = '0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (wd_reg == 4'd15) begin
          // Stalled too long: revoke and skip this requester next time.
          state_next   = IDLE;
          grant_next   = '0;
          ptr_next     = sel_reg + SW'(1);
          timeout_next = 1'b1;
        end else if (!out_ready) begin
          wd_next = wd_reg + 4'd1;
        end
`endif
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      sel_reg   <= '0;
      grant_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      sel_reg   <= sel_next;
      grant_reg <= grant_next;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Watchdog counter and one-cycle timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_reg      <= 4'd0;
      timeout_reg <= 1'b0;
    end else begin
      wd_reg      <= wd_next;
      timeout_reg <= timeout_next;
    end
  end
`endif

endmodule
